// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray-to-binary conversion and the almost-full FSM state.
package fifo_pkg;

  localparam int G2B_MAXW = 32;

  typedef enum logic {
    AF_NORMAL = 1'b0,
    AF_FULL   = 1'b1
  } afull_state_t;

  // Cumulative XOR from the MSB down. Callers zero-extend to G2B_MAXW and
  // narrow the result; bits at or above width come back as zero.
  function automatic logic [G2B_MAXW-1:0] gray2bin(input logic [G2B_MAXW-1:0] g,
                                                  input int width);
    logic [G2B_MAXW-1:0] b;
    logic                acc;
    b   = '0;
    acc = 1'b0;
    for (int i = G2B_MAXW-1; i >= 0; i--) begin
      if (i < width) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Generic two-flop synchroniser; q is the second stage with no logic between stages.
module sync_r2w #(
  parameter int WIDTH = 5
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wfifo_level.sv
// Write-domain view of the async FIFO: synced read pointer, occupancy,
// almost-full flag with hysteresis, high watermark and sticky overrun error.
module wfifo_level
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12,
  parameter int AFULL_HYST   = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic                werr_clr,
  output logic [ADDRSIZE:0]   wrptr2,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wpeak,
  output logic                werr
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH_V  = PW'(2**ADDRSIZE);
  localparam logic [PW-1:0] SET_V    = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] REL_V    = PW'(AFULL_THRESH - AFULL_HYST);

  logic [PW-1:0] rbin_w, wbin_c, diff;
  logic          over;
  afull_state_t  af_q;

  sync_r2w #(.WIDTH(PW)) u_sync (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .d      (rptr),
    .q      (wrptr2)
  );

  // Binary view of the second sync stage; it is zero whenever wrptr2 is reset,
  // and keeping it off an extra flop holds rptr->wlevel at three edges.
  always_comb begin
    rbin_w = PW'(gray2bin(G2B_MAXW'(wrptr2), PW));
    wbin_c = PW'(gray2bin(G2B_MAXW'(wptr), PW));
    diff   = wbin_c - rbin_w;
    over   = (diff > DEPTH_V);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel <= '0;
      wpeak  <= '0;
      werr   <= 1'b0;
      af_q   <= AF_NORMAL;
    end else begin
      // Raw diff is kept unsaturated so a corrupt pointer stays visible.
      wlevel <= diff;

      if (over)          werr <= 1'b1;
      else if (werr_clr) werr <= 1'b0;

      if (werr_clr)          wpeak <= diff;
      else if (diff > wpeak) wpeak <= diff;

      case (af_q)
        AF_NORMAL: if (diff >= SET_V) af_q <= AF_FULL;
        AF_FULL:   if (diff <  REL_V) af_q <= AF_NORMAL;
        default:   af_q <= AF_NORMAL;
      endcase
    end
  end

  assign walmost_full = (af_q == AF_FULL);

endmodule

// File: tb/tb_wfifo_level.sv
// Self-checking bench for wfifo_level: vector table, hand sequences, random vs model.
module tb_wfifo_level;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic [4:0] rptr = '0, wptr = '0;
  logic       werr_clr = 1'b0;
  logic [4:0] wrptr2, wlevel, wpeak;
  logic       walmost_full, werr;

  int n_chk = 0, n_fail = 0;

  wfifo_level #(.ADDRSIZE(4), .AFULL_THRESH(12), .AFULL_HYST(2)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .rptr         (rptr),
    .wptr         (wptr),
    .werr_clr     (werr_clr),
    .wrptr2       (wrptr2),
    .wlevel       (wlevel),
    .walmost_full (walmost_full),
    .wpeak        (wpeak),
    .werr         (werr)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3) ^ (g >> 4);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ptrs(input int rb, input int wb);
    rptr = b2g(5'(rb));
    wptr = b2g(5'(wb));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge wclk);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    werr_clr = 1'b0;
    step(2);
    wrst_n = 1'b1;
  endtask

  // Reference model: level = wbin(now) - rbin(two samples ago), spec flag rules.
  bit         mdl_en = 1'b0;
  logic [4:0] rh[$];
  logic [4:0] m_r2, m_lvl, m_peak;
  bit         m_af, m_err;

  task automatic mdl_init();
    rh = {5'd0, 5'd0};
    m_r2 = '0; m_lvl = '0; m_peak = '0; m_af = 1'b0; m_err = 1'b0;
  endtask

  always @(posedge wclk) begin
    if (mdl_en && wrst_n) begin
      logic [4:0] d;
      rh.push_back(rptr);
      d = g2b(wptr) - g2b(rh[rh.size()-3]);
      m_r2 = rh[rh.size()-2];
      m_lvl = d;
      if (d > 5'd16)     m_err = 1'b1;
      else if (werr_clr) m_err = 1'b0;
      if (werr_clr)        m_peak = d;
      else if (d > m_peak) m_peak = d;
      if (!m_af && d >= 5'd12)    m_af = 1'b1;
      else if (m_af && d < 5'd10) m_af = 1'b0;
      if (rh.size() > 8) void'(rh.pop_front());
    end
  end

  typedef struct {
    int rb; int wb; int lvl; bit af; bit err;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int wb, rb, occ;

    tbl[0] = '{0, 0, 0, 0, 0};
    tbl[1] = '{29, 3, 6, 0, 0};
    tbl[2] = '{0, 12, 12, 1, 0};
    tbl[3] = '{2, 12, 10, 1, 0};
    tbl[4] = '{4, 12, 8, 0, 0};
    tbl[5] = '{3, 12, 9, 0, 0};
    tbl[6] = '{16, 0, 16, 1, 0};
    tbl[7] = '{0, 17, 17, 1, 1};
    tbl[8] = '{5, 3, 30, 1, 1};
    tbl[9] = '{31, 0, 1, 0, 0};

    // Reset state
    step(3);
    chk("rst_wrptr2", wrptr2, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_afull", walmost_full, 0);
    chk("rst_wpeak", wpeak, 0);
    chk("rst_werr", werr, 0);

    // Static vectors from reset; the transient level equals wbin for two edges.
    for (int i = 0; i < 10; i++) begin
      wrst_n = 1'b0;
      set_ptrs(tbl[i].rb, tbl[i].wb);
      step(1);
      wrst_n = 1'b1;
      step(5);
      chk($sformatf("vec%0d_level", i), wlevel, tbl[i].lvl);
      chk($sformatf("vec%0d_afull", i), walmost_full, tbl[i].af);
      chk($sformatf("vec%0d_err", i), werr, tbl[i].err);
      werr_clr = 1'b1;
      step(1);
      werr_clr = 1'b0;
      chk($sformatf("vec%0d_clr_err", i), werr, tbl[i].err);
      chk($sformatf("vec%0d_clr_peak", i), wpeak, tbl[i].lvl);
    end

    // Ramp: wptr 1..12, wlevel one edge behind
    do_reset();
    set_ptrs(0, 0);
    step(1);
    for (int k = 1; k <= 12; k++) begin
      set_ptrs(0, k);
      step(1);
      chk($sformatf("ramp%0d_level", k), wlevel, k);
      chk($sformatf("ramp%0d_afull", k), walmost_full, (k >= 12) ? 1 : 0);
    end
    chk("ramp_peak", wpeak, 12);
    set_ptrs(2, 12);
    step(1);
    chk("rd2_wrptr2_e1", wrptr2, 0);
    step(1);
    chk("rd2_wrptr2_e2", wrptr2, 3);
    chk("rd2_level_e2", wlevel, 12);
    step(1);
    chk("rd2_level_e3", wlevel, 10);
    chk("rd2_afull_e3", walmost_full, 1);
    set_ptrs(3, 12);
    step(3);
    chk("rd3_level", wlevel, 9);
    chk("rd3_afull", walmost_full, 0);

    // Asynchronous reset mid-run, then reconvergence within 3 edges
    #2 wrst_n = 1'b0;
    #1;
    chk("arst_level", wlevel, 0);
    chk("arst_wrptr2", wrptr2, 0);
    chk("arst_peak", wpeak, 0);
    chk("arst_err", werr, 0);
    chk("arst_afull", walmost_full, 0);
    step(1);
    wrst_n = 1'b1;
    step(3);
    chk("reconv_level", wlevel, 9);

    // Overrun, clear with diff back to 2, then clear while overrun persists
    do_reset();
    set_ptrs(5, 3);
    step(4);
    chk("ovr_err", werr, 1);
    chk("ovr_level", wlevel, 30);
    set_ptrs(5, 7);
    step(3);
    chk("ovr_sticky", werr, 1);
    werr_clr = 1'b1;
    step(1);
    werr_clr = 1'b0;
    chk("clr_err", werr, 0);
    chk("clr_peak", wpeak, 2);
    set_ptrs(5, 3);
    step(3);
    chk("ovr2_afull", walmost_full, 1);
    werr_clr = 1'b1;
    step(1);
    werr_clr = 1'b0;
    chk("clr_setwins_err", werr, 1);
    chk("clr_setwins_peak", wpeak, 30);
    chk("clr_afull_kept", walmost_full, 1);

    // Fast reader: five increments between edges
    do_reset();
    set_ptrs(0, 12);
    step(4);
    set_ptrs(5, 12);
    step(3);
    chk("fast_level", wlevel, 7);
    chk("fast_err", werr, 0);

    // Random walk against the reference model
    do_reset();
    set_ptrs(0, 0);
    mdl_init();
    wb = 0; rb = 0;
    mdl_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step(1);
      chk("rnd_wrptr2", wrptr2, m_r2);
      chk("rnd_level", wlevel, m_lvl);
      chk("rnd_afull", walmost_full, m_af);
      chk("rnd_peak", wpeak, m_peak);
      chk("rnd_err", werr, m_err);
      occ = (wb - rb) & 31;
      if (occ < 16 && $urandom_range(0, 2) != 0) wb = (wb + 1) & 31;
      rb = (rb + $urandom_range(0, (occ < 5) ? occ : 5)) & 31;
      if ($urandom_range(0, 59) == 0) rb = (wb + 3) & 31;
      werr_clr = ($urandom_range(0, 24) == 0);
      set_ptrs(rb, wb);
    end
    mdl_en = 1'b0;
    werr_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
